usr_shift_sequencer: RTL and testbench

//   Command sequencer directly upstream of the 4-bit universal shift register.

---
 rtl/usr_shift_sequencer_if.sv | 30 +++
 rtl/usr_shift_sequencer.sv | 106 ++++++++++
 tb/tb_usr_shift_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/usr_shift_sequencer_if.sv
// Command handshake and register-drive bundle between upstream logic,
// the shift sequencer and the downstream 4-bit universal shift register.
interface usr_shift_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SER_W = 8,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_pdata;
  logic [SER_W-1:0] cmd_sdata;
  logic [1:0]       sel;
  logic [WIDTH-1:0] usr_i;
  logic             il;
  logic             ir;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_pdata, cmd_sdata,
    input  cmd_ready, sel, usr_i, il, ir, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_pdata, cmd_sdata,
    output cmd_ready, sel, usr_i, il, ir, busy, done
  );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Sequences hold / load / shift-left-N / shift-right-N commands onto the select,
// parallel and serial pins of a universal shift register, then pulses done.
module usr_shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SER_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  usr_shift_sequencer_if.slave  bus
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [SER_W-1:0] sreg;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] eff_cnt;
  logic             accept;

  // Shift counts above the fill-word width saturate silently.
  assign eff_cnt = (bus.cmd_cnt > CNT_W'(SER_W)) ? CNT_W'(SER_W) : bus.cmd_cnt;
  assign accept  = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= OP_HOLD;
      sreg          <= SER_W'(0);
      rem           <= CNT_W'(0);
      bus.cmd_ready <= 1'b1;
      bus.sel       <= 2'b00;
      bus.usr_i     <= WIDTH'(0);
      bus.il        <= 1'b0;
      bus.ir        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q          <= bus.cmd_op;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.cmd_op == OP_LOAD) begin
              state     <= LOAD;
              bus.sel   <= OP_LOAD;
              bus.usr_i <= bus.cmd_pdata;
            end else if ((bus.cmd_op != OP_HOLD) && (eff_cnt != CNT_W'(0))) begin
              // First serial bit goes out on the very next cycle.
              state   <= SHIFT;
              bus.sel <= bus.cmd_op;
              bus.ir  <= (bus.cmd_op == OP_SHR) && bus.cmd_sdata[0];
              bus.il  <= (bus.cmd_op == OP_SHL) && bus.cmd_sdata[0];
              sreg    <= bus.cmd_sdata >> 1;
              rem     <= eff_cnt - CNT_W'(1);
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        LOAD: begin
          state    <= DONE;
          bus.sel  <= 2'b00;
          bus.done <= 1'b1;
        end
        SHIFT: begin
          if (rem == CNT_W'(0)) begin
            state    <= DONE;
            bus.sel  <= 2'b00;
            bus.il   <= 1'b0;
            bus.ir   <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            bus.ir <= (op_q == OP_SHR) && sreg[0];
            bus.il <= (op_q == OP_SHL) && sreg[0];
            sreg   <= sreg >> 1;
            rem    <= rem - CNT_W'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.sel       <= 2'b00;
          bus.il        <= 1'b0;
          bus.ir        <= 1'b0;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: directed and random commands checked
// cycle by cycle against a per-command expected trace and a downstream register.
module tb_usr_shift_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned SER_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int NRAND = 30;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] last_load;
  logic [3:0] dq;

  always #5 clk = ~clk;

  usr_shift_sequencer_if #(.WIDTH(WIDTH), .SER_W(SER_W), .CNT_W(CNT_W)) ifc ();

  usr_shift_sequencer #(.WIDTH(WIDTH), .SER_W(SER_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Downstream universal shift register; it has no reset and keeps its value.
  always @(posedge clk) begin
    case (ifc.sel)
      2'b01:   dq <= {ifc.ir, dq[3:1]};
      2'b10:   dq <= {dq[2:0], ifc.il};
      2'b11:   dq <= ifc.usr_i;
      default: dq <= dq;
    endcase
  end

  function automatic logic [10:0] vec(logic [1:0] s, logic [3:0] u, logic l, logic r,
                                      logic b, logic d, logic rdy);
    return {s, u, l, r, b, d, rdy};
  endfunction

  function automatic logic [10:0] obs();
    return {ifc.sel, ifc.usr_i, ifc.il, ifc.ir, ifc.busy, ifc.done, ifc.cmd_ready};
  endfunction

  task automatic check(input string tag, input logic [10:0] o, input logic [10:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Register contents after a whole command, from the shift rules alone.
  function automatic logic [3:0] ref_final(logic [3:0] start, logic [1:0] op, int eff,
                                           logic [3:0] pd, logic [7:0] sd);
    logic [3:0] v;
    v = start;
    if (op == 2'b11) v = pd;
    for (int i = 0; i < eff; i++) begin
      if (op == 2'b01) v = {sd[i], v[3:1]};
      else             v = {v[2:0], sd[i]};
    end
    return v;
  endfunction

  // Called on a falling edge with the sequencer idle; returns on the falling
  // edge where it is idle again. With chain set, valid stays high and the
  // next command is presented right after this one is accepted.
  task automatic issue(input string tag, input logic [1:0] op, input logic [3:0] cnt,
                       input logic [3:0] pd, input logic [7:0] sd, input bit chain,
                       input logic [1:0] nop, input logic [3:0] ncnt,
                       input logic [3:0] npd, input logic [7:0] nsd);
    logic [10:0] q[$];
    logic [3:0]  start;
    int          eff;
    logic        b;
    check({tag, "_idle"}, obs(), vec(2'b00, last_load, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    start = dq;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_cnt   = cnt;
    ifc.cmd_pdata = pd;
    ifc.cmd_sdata = sd;
    eff = ((op == 2'b01) || (op == 2'b10)) ? ((int'(cnt) > 8) ? 8 : int'(cnt)) : 0;
    if (op == 2'b11) begin
      last_load = pd;
      q.push_back(vec(2'b11, pd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    for (int i = 0; i < eff; i++) begin
      b = sd[i];
      q.push_back(vec(op, last_load, (op == 2'b10) ? b : 1'b0, (op == 2'b01) ? b : 1'b0,
                      1'b1, 1'b0, 1'b0));
    end
    q.push_back(vec(2'b00, last_load, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    q.push_back(vec(2'b00, last_load, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    if (chain) begin
      ifc.cmd_op    = nop;
      ifc.cmd_cnt   = ncnt;
      ifc.cmd_pdata = npd;
      ifc.cmd_sdata = nsd;
    end else begin
      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = 2'($urandom);
      ifc.cmd_cnt   = 4'($urandom);
      ifc.cmd_pdata = 4'($urandom);
      ifc.cmd_sdata = 8'($urandom);
    end
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s_cyc%0d", tag, i + 1), obs(), q[i]);
      if (i < q.size() - 1) @(negedge clk);
    end
    check({tag, "_regout"}, 11'(dq), 11'(ref_final(start, op, eff, pd, sd)));
  endtask

  logic [1:0] rop [NRAND];
  logic [3:0] rcnt[NRAND];
  logic [3:0] rpd [NRAND];
  logic [7:0] rsd [NRAND];
  bit         rch [NRAND];
  logic [3:0] held;

  initial begin
    rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'b00;
    ifc.cmd_cnt   = 4'd0;
    ifc.cmd_pdata = 4'd0;
    ifc.cmd_sdata = 8'd0;
    last_load     = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_state", obs(), vec(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rst = 1'b1;
    @(negedge clk);

    issue("load_1010", 2'b11, 4'd0, 4'b1010, 8'h00, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("load_0000", 2'b11, 4'd0, 4'b0000, 8'h00, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("shr3",      2'b01, 4'd3, 4'b1111, 8'b00000101, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("load_0001", 2'b11, 4'd0, 4'b0001, 8'h00, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("shl2",      2'b10, 4'd2, 4'b0000, 8'b00000011, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("shr_cnt0",  2'b01, 4'd0, 4'b0110, 8'hff, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("shl_cnt15", 2'b10, 4'd15, 4'b0110, 8'b10110010, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("shr_cnt9",  2'b01, 4'd9, 4'b0110, 8'b01101101, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("hold",      2'b00, 4'd5, 4'b1001, 8'hff, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    issue("hs_first",  2'b11, 4'd0, 4'b0101, 8'h00, 1'b1, 2'b01, 4'd4, 4'b1110, 8'b1001);
    issue("hs_second", 2'b01, 4'd4, 4'b1110, 8'b1001, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);

    for (int i = 0; i < NRAND; i++) begin
      rop[i]  = 2'($urandom);
      rcnt[i] = 4'($urandom);
      rpd[i]  = 4'($urandom);
      rsd[i]  = 8'($urandom);
      rch[i]  = (i < NRAND - 1) && ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < NRAND; i++) begin
      issue($sformatf("rand%0d", i), rop[i], rcnt[i], rpd[i], rsd[i], rch[i],
            rop[(i + 1) % NRAND], rcnt[(i + 1) % NRAND], rpd[(i + 1) % NRAND],
            rsd[(i + 1) % NRAND]);
    end

    // Reset asserted in the middle of a long right shift.
    issue("pre_rst_load", 2'b11, 4'd0, 4'b1100, 8'h00, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 2'b01;
    ifc.cmd_cnt   = 4'd8;
    ifc.cmd_sdata = 8'hff;
    @(posedge clk);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("rst_in_shift", obs(), vec(2'b01, 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    held = dq;
    #2 rst = 1'b0;
    #1 check("rst_async", obs(), vec(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    last_load = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_reg_kept", 11'(dq), 11'(held));
    rst = 1'b1;
    @(negedge clk);
    check("rst_reg_after", 11'(dq), 11'(held));
    issue("post_rst_shl", 2'b10, 4'd3, 4'd0, 8'b010, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
